// File: rtl/mdio_receptor_pkg.sv
// Shared definitions for the MDIO Clause-22 frame responder.
// Frame layout (bit 0 first on the wire): ST[0:1] OP[2:3] PHYADR[4:8] REGADR[9:13]
// TA[14:15] DATA[16:31]. Header offsets below index the 16-bit header word as it
// sits in the shift register after bit 15 (bit 0 of the frame ends up at [15]).
package mdio_receptor_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StWrData,
        StRdData,
        StSkip
    } state_e;

    localparam logic [1:0] MdioSt     = 2'b01;
    localparam logic [1:0] MdioOpWr   = 2'b01;
    localparam logic [1:0] MdioOpRd   = 2'b10;
    localparam int unsigned MdioFrameLen = 32;

    // Bit positions within the frame, as bit_cnt values.
    localparam logic [4:0] LastAddrBit  = 5'd13;
    localparam logic [4:0] LastHdrBit   = 5'd15;
    localparam logic [4:0] FirstDataBit = 5'd16;
    localparam logic [4:0] LastBit      = 5'(MdioFrameLen - 1);

    // Field LSB offsets inside the 16-bit header word.
    localparam int unsigned HdrStLsb  = 14;
    localparam int unsigned HdrOpLsb  = 12;
    localparam int unsigned HdrPhyLsb = 7;

    // Picks the state following the header: payload phase for a well-formed frame
    // addressed to us, otherwise ride out the rest of the frame silently.
    function automatic state_e decode_header(input logic [15:0] hdr,
                                             input logic [4:0]  phy_addr);
        logic [1:0] st;
        logic [1:0] op;
        logic [4:0] phy;
        st  = hdr[HdrStLsb +: 2];
        op  = hdr[HdrOpLsb +: 2];
        phy = hdr[HdrPhyLsb +: 5];
        if (st != MdioSt || (op != MdioOpWr && op != MdioOpRd)) begin
            return StSkip;
        end else if (phy != phy_addr) begin
            return StSkip;
        end else if (op == MdioOpWr) begin
            return StWrData;
        end else begin
            return StRdData;
        end
    endfunction

endpackage

// File: rtl/mdc_edge_detect.sv
// Detects rising/falling edges of the management clock in the clk domain.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   mdc               management clock from the generator
//   mdc_rise/mdc_fall one-clk pulses on mdc transitions
module mdc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    logic mdc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= mdc;
        end
    end

    assign mdc_rise = mdc & ~mdc_q;
    assign mdc_fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_receptor.sv
// MDIO management-frame responder (PHY side). Decodes 32-bit Clause-22 frames
// sampled on mdc rising edges, issues register writes and serialises read data.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   mdc         management clock from the generator
//   mdio_out    serial data from the generator
//   mdio_oe     generator drive enable (1 = generator owns the line)
//   rd_data     register-bank read data for addr
//   mdio_in     serial read data back to the generator
//   addr        decoded REGADR (held until the next header)
//   wr_data     write data (held until the next completed write)
//   wr_stb      one-clk write strobe
//   mdio_done   one-clk end-of-frame pulse for completed writes/reads
module mdio_receptor
    import mdio_receptor_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_out,
    input  logic        mdio_oe,
    input  logic [15:0] rd_data,
    output logic        mdio_in,
    output logic [4:0]  addr,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    output logic        mdio_done
);

    logic mdc_rise;
    logic mdc_fall;

    mdc_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .mdc      (mdc),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    // Only 15 bits need storing: the 16th comes straight off mdio_out in rx_shift.
    logic [14:0] rx_q, rx_d;
    // Bit 15 of rd_data is driven at load time, so only the remaining 15 are kept.
    logic [14:0] tx_q, tx_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_stb_q, wr_stb_d;
    logic        done_q, done_d;
    logic        mdio_in_q, mdio_in_d;
    logic [15:0] rx_shift;

    assign rx_shift = {rx_q, mdio_out};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = 1'b0;
        done_d    = 1'b0;
        mdio_in_d = mdio_in_q;

        unique case (state_q)
            StIdle: begin
                mdio_in_d = 1'b0;
                if (mdc_rise && mdio_oe) begin
                    rx_d      = {14'b0, mdio_out};
                    bit_cnt_d = 5'd1;
                    state_d   = StHeader;
                end
            end
            StHeader: begin
                if (mdc_rise) begin
                    if (!mdio_oe && bit_cnt_q < LastHdrBit) begin
                        state_d   = StIdle;
                        bit_cnt_d = 5'd0;
                    end else begin
                        rx_d      = rx_shift[14:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == LastAddrBit) begin
                            addr_d = rx_shift[4:0];
                        end
                        if (bit_cnt_q == LastHdrBit) begin
                            state_d = decode_header(rx_shift, PHY_ADDR);
                        end
                    end
                end
            end
            StWrData: begin
                if (mdc_rise) begin
                    if (!mdio_oe) begin
                        state_d   = StIdle;
                        bit_cnt_d = 5'd0;
                    end else begin
                        rx_d      = rx_shift[14:0];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == LastBit) begin
                            wr_data_d = rx_shift;
                            wr_stb_d  = 1'b1;
                            done_d    = 1'b1;
                            state_d   = StIdle;
                        end
                    end
                end
            end
            StRdData: begin
                if (mdc_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == LastBit) begin
                        done_d    = 1'b1;
                        mdio_in_d = 1'b0;
                        state_d   = StIdle;
                    end
                end else if (mdc_fall) begin
                    // The fall before rise k sees bit_cnt == k; the first one loads.
                    if (bit_cnt_q == FirstDataBit) begin
                        tx_d      = rd_data[14:0];
                        mdio_in_d = rd_data[15];
                    end else begin
                        tx_d      = {tx_q[13:0], 1'b0};
                        mdio_in_d = tx_q[14];
                    end
                end
            end
            StSkip: begin
                if (mdc_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 5'd0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            mdio_in_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            done_q    <= done_d;
            mdio_in_q <= mdio_in_d;
        end
    end

    assign mdio_in   = mdio_in_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign wr_stb    = wr_stb_q;
    assign mdio_done = done_q;

endmodule
